line_collision_ctrl: RTL and testbench
======================================

Name: line_collision_ctrl

Overview:
- Game-control stage directly downstream of the vertical-line renderers.
- Consumes each line's raw pixel (sha2) and the player-cube pixel; detects cube/line collision per frame, keeps the survival score, and runs the play/hit/over state machine.
- Drives back into the line renderers: start_machine, load_counter, stop (run enable), flash.
- Frame-synchronous decisions; pixel-rate collision sampling on clk.

Parameters:
- NUM_LINES, 2, number of line renderers feeding line_pix
- SCORE_FRAMES, 60, frames survived per score increment
- FLASH_FRAMES, 15, frames per flash half-period
- HIT_FRAMES, 120, frames spent in HIT before OVER

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- frame  in  1  frame strobe level; rising edge marks end of visible frame
- btn_start  in  1  raw start button, asynchronous
- line_pix  in  NUM_LINES  raw line pixels (sha2 of each renderer), pixel-aligned
- cube_pix  in  1  player cube pixel, pixel-aligned with line_pix
- start_machine  out  1  enables line motion FSMs
- load_counter  out  1  holds line position counters at start value
- stop  out  1  run enable to renderers: 1 = lines move and draw solid, 0 = frozen, drawn gated by flash
- flash  out  1  blink enable while stop=0
- hit  out  1  high in HIT and OVER
- score  out  8  frames-survived score, binary, saturating
- state  out  2  0 IDLE, 1 LOAD, 2 PLAY/HIT, 3 OVER (debug; HIT encodes 2 with hit=1)

Behaviour:
- Reset (async, reset_n=0): state IDLE; load_counter=1; start_machine=0; stop=0; flash=0; hit=0; score=0; all counters 0; synchronizer flops 0.
- btn_start: 2-flop synchronizer plus rising-edge detect -> start_p (one clk). Latency 3 clk from raw edge.
- frame: registered; frame_p = frame & ~frame_q (one clk).
- Collision flag coll: set on any clk where cube_pix & |line_pix; cleared on frame_p. Set on the frame_p cycle itself carries into the next frame (clear loses to set).
- IDLE: load_counter=1, stop=0, start_machine=0; flash toggles every FLASH_FRAMES frame_p. start_p -> LOAD, score cleared.
- LOAD: load_counter=1, flash=1; stays until next frame_p (line counters are frame-clocked), then PLAY. Exactly one full frame_p with load_counter high is guaranteed.
- PLAY: load_counter=0, start_machine=1, stop=1, flash=1. On frame_p: if coll -> HIT (no score increment that frame); else frame counter++; at SCORE_FRAMES wraps to 0 and score++ (saturate at 255). start_p ignored.
- HIT: start_machine=0, stop=0, hit=1; flash starts at 0 on entry, toggles every FLASH_FRAMES frame_p; after HIT_FRAMES frame_p -> OVER.
- OVER: stop=0, flash=1 (lines shown frozen, solid), hit=1, score held. start_p -> LOAD, score and counters cleared, hit=0.
- start_p in LOAD, PLAY, HIT ignored.
- Counters 8-bit; compare against parameter-1, reset to 0 on every state entry.
- All outputs registered; transitions take effect the clk after frame_p/start_p.
- Reset mid-operation: immediate return to reset values regardless of state.

Decomposition:
- Shared package: state encoding constants (ST_IDLE, ST_LOAD, ST_PLAY, ST_HIT, ST_OVER), score width 8.
- One sub-module: edge_sync (2-flop synchronizer + rising-edge pulse), instantiated for btn_start; frame uses its edge stage only.
- FSM, frame counters, collision latch in top.

Test Plan:
- Reset then 3 frames idle -> load_counter=1, stop=0, score=0, flash toggling every 15 frames.
- btn_start pulse in IDLE -> LOAD; load_counter stays 1 through next frame_p; PLAY one clk later with stop=1, start_machine=1.
- PLAY 180 frames, no overlap -> score=3; 15360 frames -> score saturates at 255.
- cube_pix & line_pix[1] high for one pixel in frame 70 -> at that frame_p enter HIT, score stays 1, stop=0, hit=1; OVER after 120 more frame_p.
- Overlap asserted exactly on frame_p cycle -> no HIT that frame; HIT at following frame_p.
- btn_start in PLAY ignored; in OVER -> LOAD, score=0, hit=0; reset_n low mid-HIT -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/line_collision_ctrl_pkg.sv
// Shared types and helpers for the line collision / game control stage.
// Holds the FSM encoding, the debug state code mapping and the score width.
package line_collision_ctrl_pkg;

  localparam int SCORE_W = 8;
  localparam int CNT_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_HIT,
    ST_OVER
  } state_e;

  // Two-bit debug code; PLAY and HIT share a code and are told apart by hit.
  localparam logic [1:0] DBG_IDLE = 2'd0;
  localparam logic [1:0] DBG_LOAD = 2'd1;
  localparam logic [1:0] DBG_RUN  = 2'd2;
  localparam logic [1:0] DBG_OVER = 2'd3;

  function automatic logic [1:0] state_code(input state_e s);
    logic [1:0] code;
    code = DBG_IDLE;
    case (s)
      ST_IDLE: code = DBG_IDLE;
      ST_LOAD: code = DBG_LOAD;
      ST_PLAY: code = DBG_RUN;
      ST_HIT:  code = DBG_RUN;
      ST_OVER: code = DBG_OVER;
      default: code = DBG_IDLE;
    endcase
    return code;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == {SCORE_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/line_collision_ctrl_edge_sync.sv
// Optional 2-flop synchronizer followed by a rising-edge detector.
// With SYNC=0 only the edge stage is kept, for inputs already on clk.
module line_collision_ctrl_edge_sync #(
  parameter bit SYNC = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise
);

  logic w_level;
  logic r_q;

  generate
    if (SYNC) begin : g_sync
      logic r_s1;
      logic r_s2;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_s1 <= 1'b0;
          r_s2 <= 1'b0;
        end else begin
          r_s1 <= i_d;
          r_s2 <= r_s1;
        end
      end
      assign w_level = r_s2;
    end else begin : g_raw
      assign w_level = i_d;
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= 1'b0;
    end else begin
      r_q <= w_level;
    end
  end

  assign o_rise = w_level & ~r_q;

endmodule

// File: rtl/line_collision_ctrl.sv
// Game control downstream of the line renderers: per-frame cube/line collision,
// survival score and the IDLE/LOAD/PLAY/HIT/OVER machine driving the renderers.
module line_collision_ctrl
  import line_collision_ctrl_pkg::*;
#(
  parameter int NUM_LINES    = 2,
  parameter int SCORE_FRAMES = 60,
  parameter int FLASH_FRAMES = 15,
  parameter int HIT_FRAMES   = 120
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 frame,
  input  logic                 btn_start,
  input  logic [NUM_LINES-1:0] line_pix,
  input  logic                 cube_pix,
  output logic                 start_machine,
  output logic                 load_counter,
  output logic                 stop,
  output logic                 flash,
  output logic                 hit,
  output logic [SCORE_W-1:0]   score,
  output logic [1:0]           state
);

  localparam logic [CNT_W-1:0] SCORE_LAST = CNT_W'(SCORE_FRAMES - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_FRAMES - 1);
  localparam logic [CNT_W-1:0] HIT_LAST   = CNT_W'(HIT_FRAMES - 1);

  logic w_start_p;
  logic w_frame_p;
  logic w_overlap;

  state_e r_state;
  state_e w_state_nxt;

  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   r_fl_cnt;
  logic [CNT_W-1:0]   w_fl_cnt_nxt;
  logic               r_flash;
  logic               w_flash_nxt;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] w_score_nxt;
  logic               r_coll;

  logic       r_load_counter;
  logic       r_start_machine;
  logic       r_stop;
  logic       r_hit;
  logic [1:0] r_state_dbg;

  line_collision_ctrl_edge_sync #(.SYNC(1'b1)) u_btn_sync (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_d     (btn_start),
    .o_rise  (w_start_p)
  );

  line_collision_ctrl_edge_sync #(.SYNC(1'b0)) u_frame_edge (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_d     (frame),
    .o_rise  (w_frame_p)
  );

  assign w_overlap = cube_pix & (|line_pix);

  // A hit on the frame_p cycle itself is kept for the next frame's decision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_coll <= 1'b0;
    end else begin
      r_coll <= w_overlap | (r_coll & ~w_frame_p);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_fl_cnt_nxt = r_fl_cnt;
    w_flash_nxt  = r_flash;
    w_score_nxt  = r_score;

    case (r_state)
      ST_IDLE: begin
        if (w_start_p) begin
          w_state_nxt = ST_LOAD;
          w_score_nxt = '0;
        end else if (w_frame_p) begin
          if (r_fl_cnt == FLASH_LAST) begin
            w_fl_cnt_nxt = '0;
            w_flash_nxt  = ~r_flash;
          end else begin
            w_fl_cnt_nxt = r_fl_cnt + 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (w_frame_p) begin
          w_state_nxt = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (w_frame_p) begin
          if (r_coll) begin
            w_state_nxt = ST_HIT;
          end else if (r_cnt == SCORE_LAST) begin
            w_cnt_nxt   = '0;
            w_score_nxt = sat_inc(r_score);
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      ST_HIT: begin
        if (w_frame_p) begin
          if (r_cnt == HIT_LAST) begin
            w_state_nxt = ST_OVER;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
          if (r_fl_cnt == FLASH_LAST) begin
            w_fl_cnt_nxt = '0;
            w_flash_nxt  = ~r_flash;
          end else begin
            w_fl_cnt_nxt = r_fl_cnt + 1'b1;
          end
        end
      end
      ST_OVER: begin
        if (w_start_p) begin
          w_state_nxt = ST_LOAD;
          w_score_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Every state starts with fresh counters; HIT blinks starting dark,
    // the other entered states show the lines solid.
    if (w_state_nxt != r_state) begin
      w_cnt_nxt    = '0;
      w_fl_cnt_nxt = '0;
      w_flash_nxt  = (w_state_nxt != ST_HIT);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt           <= '0;
      r_fl_cnt        <= '0;
      r_flash         <= 1'b0;
      r_score         <= '0;
      r_load_counter  <= 1'b1;
      r_start_machine <= 1'b0;
      r_stop          <= 1'b0;
      r_hit           <= 1'b0;
      r_state_dbg     <= DBG_IDLE;
    end else begin
      r_cnt           <= w_cnt_nxt;
      r_fl_cnt        <= w_fl_cnt_nxt;
      r_flash         <= w_flash_nxt;
      r_score         <= w_score_nxt;
      r_load_counter  <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_LOAD);
      r_start_machine <= (w_state_nxt == ST_PLAY);
      r_stop          <= (w_state_nxt == ST_PLAY);
      r_hit           <= (w_state_nxt == ST_HIT) || (w_state_nxt == ST_OVER);
      r_state_dbg     <= state_code(w_state_nxt);
    end
  end

  assign start_machine = r_start_machine;
  assign load_counter  = r_load_counter;
  assign stop          = r_stop;
  assign flash         = r_flash;
  assign hit           = r_hit;
  assign score         = r_score;
  assign state         = r_state_dbg;

endmodule

// File: tb/tb_line_collision_ctrl.sv
// Bench for line_collision_ctrl: directed sequence plus random pixel/button traffic,
// every cycle compared against a frame-level game model.
module tb_line_collision_ctrl;

  localparam int NL = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          frame = 1'b0;
  logic          btn_start = 1'b0;
  logic [NL-1:0] line_pix = '0;
  logic          cube_pix = 1'b0;
  logic          start_machine;
  logic          load_counter;
  logic          stop;
  logic          flash;
  logic          hit;
  logic [7:0]    score;
  logic [1:0]    state;

  int n_cmp  = 0;
  int n_fail = 0;

  line_collision_ctrl #(
    .NUM_LINES    (NL),
    .SCORE_FRAMES (60),
    .FLASH_FRAMES (15),
    .HIT_FRAMES   (120)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .frame         (frame),
    .btn_start     (btn_start),
    .line_pix      (line_pix),
    .cube_pix      (cube_pix),
    .start_machine (start_machine),
    .load_counter  (load_counter),
    .stop          (stop),
    .flash         (flash),
    .hit           (hit),
    .score         (score),
    .state         (state)
  );

  always #5 clk = ~clk;

  // Game model: counts frames per phase and derives outputs arithmetically.
  typedef enum int {M_IDLE, M_LOAD, M_PLAY, M_HIT, M_OVER} mode_e;
  mode_e m_mode;
  int    m_idle_fr, m_played, m_hit_fr, m_btn_run, m_score;
  bit    m_coll, m_frame_q;

  task automatic model_reset();
    m_mode    = M_IDLE;
    m_idle_fr = 0;
    m_played  = 0;
    m_hit_fr  = 0;
    m_btn_run = 0;
    m_score   = 0;
    m_coll    = 1'b0;
    m_frame_q = 1'b0;
  endtask

  task automatic model_clock();
    bit fp, ov, start;
    if (!reset_n) begin
      model_reset();
      return;
    end
    fp        = frame && !m_frame_q;
    m_frame_q = frame;
    ov        = cube_pix && (line_pix != '0);
    m_btn_run = btn_start ? m_btn_run + 1 : 0;
    start     = (m_btn_run == 3);
    case (m_mode)
      M_IDLE: begin
        if (start) begin m_mode = M_LOAD; m_score = 0; end
        else if (fp) m_idle_fr++;
      end
      M_LOAD: if (fp) begin m_mode = M_PLAY; m_played = 0; end
      M_PLAY: begin
        if (fp) begin
          if (m_coll) begin
            m_mode = M_HIT; m_hit_fr = 0;
          end else begin
            m_played++;
            m_score = (m_played / 60 > 255) ? 255 : m_played / 60;
          end
        end
      end
      M_HIT: begin
        if (fp) begin
          m_hit_fr++;
          if (m_hit_fr == 120) m_mode = M_OVER;
        end
      end
      M_OVER: if (start) begin m_mode = M_LOAD; m_score = 0; end
      default: m_mode = M_IDLE;
    endcase
    m_coll = ov || (m_coll && !fp);
  endtask

  function automatic logic [14:0] exp_vec();
    logic [1:0] sc;
    logic fl;
    case (m_mode)
      M_IDLE:  begin sc = 2'd0; fl = ((m_idle_fr / 15) % 2) == 1; end
      M_LOAD:  begin sc = 2'd1; fl = 1'b1; end
      M_PLAY:  begin sc = 2'd2; fl = 1'b1; end
      M_HIT:   begin sc = 2'd2; fl = ((m_hit_fr / 15) % 2) == 1; end
      default: begin sc = 2'd3; fl = 1'b1; end
    endcase
    return {sc, (m_mode == M_HIT) || (m_mode == M_OVER), fl,
            m_mode == M_PLAY, m_mode == M_PLAY,
            (m_mode == M_IDLE) || (m_mode == M_LOAD), 8'(m_score)};
  endfunction

  function automatic logic [14:0] dut_vec();
    return {state, hit, flash, stop, start_machine, load_counter, score};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    chk("cycle{state,hit,flash,stop,sm,lc,score}", 32'(dut_vec()), 32'(exp_vec()));
  endtask

  // mode 0: no overlap, 1: overlap on one mid-frame pixel, 2: overlap on the
  // frame_p cycle only, 3: sparse random overlap
  task automatic do_frame(input int len, input int mode);
    int pos;
    pos = $urandom_range(1, len - 1);
    for (int c = 0; c < len; c++) begin
      frame    = (c == 0);
      cube_pix = 1'b0;
      line_pix = '0;
      case (mode)
        1: if (c == pos) begin cube_pix = 1'b1; line_pix = 2'b10; end
        2: if (c == 0) begin cube_pix = 1'b1; line_pix = 2'b01; end
        3: begin
          cube_pix = ($urandom_range(0, 40) == 0);
          line_pix = NL'($urandom);
        end
        default: begin
          cube_pix = 1'($urandom_range(0, 1));
          line_pix = cube_pix ? '0 : NL'($urandom);
        end
      endcase
      step();
    end
    frame    = 1'b0;
    cube_pix = 1'b0;
    line_pix = '0;
  endtask

  task automatic press();
    frame     = 1'b0;
    cube_pix  = 1'b0;
    line_pix  = '0;
    btn_start = 1'b1;
    repeat (3) step();
    btn_start = 1'b0;
    repeat (3) step();
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_state"}, 32'(state), 32'd0);
    chk({pfx, "_load_counter"}, 32'(load_counter), 32'd1);
    chk({pfx, "_start_machine"}, 32'(start_machine), 32'd0);
    chk({pfx, "_stop"}, 32'(stop), 32'd0);
    chk({pfx, "_flash"}, 32'(flash), 32'd0);
    chk({pfx, "_hit"}, 32'(hit), 32'd0);
    chk({pfx, "_score"}, 32'(score), 32'd0);
  endtask

  initial begin
    int r;
    model_reset();
    #12;
    chk_reset_vals("reset");
    reset_n = 1'b1;

    // idle: flash toggles every 15 frames
    repeat (20) do_frame(3, 0);
    chk("idle_flash_on", 32'(flash), 32'd1);
    chk("idle_load_counter", 32'(load_counter), 32'd1);
    chk("idle_stop", 32'(stop), 32'd0);
    repeat (12) do_frame(3, 0);
    chk("idle_flash_off", 32'(flash), 32'd0);

    // start -> LOAD until next frame_p -> PLAY
    press();
    chk("load_state", 32'(state), 32'd1);
    chk("load_counter_held", 32'(load_counter), 32'd1);
    chk("load_flash", 32'(flash), 32'd1);
    do_frame(3, 0);
    chk("play_state", 32'(state), 32'd2);
    chk("play_stop", 32'(stop), 32'd1);
    chk("play_start_machine", 32'(start_machine), 32'd1);

    // collision in frame 70 -> HIT with score 1
    for (int i = 1; i <= 70; i++) do_frame(4, (i == 69) ? 1 : 0);
    chk("hit_hit", 32'(hit), 32'd1);
    chk("hit_stop", 32'(stop), 32'd0);
    chk("hit_score", 32'(score), 32'd1);
    chk("hit_flash", 32'(flash), 32'd0);
    repeat (119) do_frame(3, 0);
    chk("hit_still", 32'(state), 32'd2);
    do_frame(3, 0);
    chk("over_state", 32'(state), 32'd3);
    chk("over_flash", 32'(flash), 32'd1);
    chk("over_score", 32'(score), 32'd1);

    // restart from OVER, 180 clean frames -> score 3
    press();
    chk("restart_state", 32'(state), 32'd1);
    chk("restart_score", 32'(score), 32'd0);
    chk("restart_hit", 32'(hit), 32'd0);
    do_frame(3, 0);
    repeat (180) do_frame(3, 0);
    chk("score_180", 32'(score), 32'd3);

    // button ignored in PLAY; overlap on frame_p deferred one frame
    press();
    chk("play_btn_ignored", 32'(state), 32'd2);
    do_frame(3, 2);
    chk("fp_overlap_no_hit", 32'(hit), 32'd0);
    do_frame(3, 0);
    chk("fp_overlap_late_hit", 32'(hit), 32'd1);
    repeat (50) do_frame(3, 3);

    // asynchronous reset mid-HIT
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    model_reset();
    step();
    step();
    reset_n = 1'b1;

    // saturation
    press();
    do_frame(3, 0);
    repeat (15400) do_frame(3, 0);
    chk("score_saturated", 32'(score), 32'd255);

    // random traffic
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        press();
      end else begin
        r = $urandom_range(0, 15);
        do_frame($urandom_range(3, 8), (r == 0) ? 1 : (r == 1) ? 2 : (r < 5) ? 3 : 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
